block_operand_fetch: RTL

Upstream operand loader for the 2x2 block multiplier. Given block indices (i, j, k), it reads the A block (rows 2i..2i+1, cols 2k..2k+1) and the B block (rows 2k..2k+1, cols 2j..2j+1) from the shared single-port RAM. It holds the eight words on its outputs and pulses `done` so the control unit can fire `start_mac`. It is read-only and never drives the RAM write enable.

---
 rtl/matmul_pkg.sv | 28 ++
 rtl/block_addr_gen.sv | 51 +++++
 rtl/block_operand_fetch.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared definitions for the 2x2 block matrix multiplier.
//               Holds the word-address map of the A, B and C matrices in
//               the shared RAM, the matrix side, and the operand-fetch
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

  // Address map (row-major, one element per word)
  localparam int DIM    = 8;
  localparam int A_BASE = 0;
  localparam int B_BASE = 64;
  localparam int C_BASE = 128;

  // Number of words in one A block plus one B block
  localparam int N_SLOTS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/block_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : block_addr_gen
// Description : Combinational block-element address generator.
//               Maps block indices (i, j, k) and a slot number 0..7 to a
//               RAM word address. Slots 0..3 walk the A block
//               (rows 2i.., cols 2k..), slots 4..7 walk the B block
//               (rows 2k.., cols 2j..), each in 11, 12, 21, 22 order.
// Ports       : blk_i_i, blk_j_i, blk_k_i - block indices
//               slot_i                    - element slot 0..7
//               addr_o                    - word address
// Revision    : 1.0 - initial release
// ============================================================================
module block_addr_gen #(
  parameter int ADDR_W = 9,
  parameter int IDX_W  = 4,
  parameter int DIM    = 8,
  parameter int A_BASE = 0,
  parameter int B_BASE = 64
) (
  input  logic [IDX_W-1:0]  blk_i_i,
  input  logic [IDX_W-1:0]  blk_j_i,
  input  logic [IDX_W-1:0]  blk_k_i,
  input  logic [2:0]        slot_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] w_row_blk;
  logic [ADDR_W-1:0] w_col_blk;
  logic [ADDR_W-1:0] w_base;

  // Working directly in ADDR_W bits gives the same result as computing the
  // full-width product and truncating, since + and * commute with mod 2^N.
  always_comb begin
    if (slot_i[2]) begin
      w_row_blk = ADDR_W'(blk_k_i);
      w_col_blk = ADDR_W'(blk_j_i);
      w_base    = ADDR_W'(B_BASE);
    end else begin
      w_row_blk = ADDR_W'(blk_i_i);
      w_col_blk = ADDR_W'(blk_k_i);
      w_base    = ADDR_W'(A_BASE);
    end
    // slot[1] selects the second row of the block, slot[0] the second column
    addr_o = w_base
           + ((w_row_blk << 1) + ADDR_W'(slot_i[1])) * ADDR_W'(DIM)
           + (w_col_blk << 1) + ADDR_W'(slot_i[0]);
  end

endmodule : block_addr_gen
`default_nettype wire

// File: rtl/block_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : block_operand_fetch
// Description : Loads one 2x2 A block and one 2x2 B block from the shared
//               single-port RAM for the block multiplier, holds the eight
//               words on its outputs and pulses done. Read-only.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               start, blk_i/j/k   - request and block indices (IDLE only)
//               ram_r_data         - RAM data, one cycle after its address
//               ram_addr           - RAM read address (0 outside FETCH)
//               busy, done, err    - status; done/err are one-cycle pulses
//               a_11..b_22         - fetched operands, held until replaced
// Revision    : 1.0 - initial release
// ============================================================================
module block_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int IDX_W  = 4,
  parameter int DIM    = matmul_pkg::DIM,
  parameter int A_BASE = matmul_pkg::A_BASE,
  parameter int B_BASE = matmul_pkg::B_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  blk_i,
  input  logic [IDX_W-1:0]  blk_j,
  input  logic [IDX_W-1:0]  blk_k,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] a_11,
  output logic [DATA_W-1:0] a_12,
  output logic [DATA_W-1:0] a_21,
  output logic [DATA_W-1:0] a_22,
  output logic [DATA_W-1:0] b_11,
  output logic [DATA_W-1:0] b_12,
  output logic [DATA_W-1:0] b_21,
  output logic [DATA_W-1:0] b_22
);

  import matmul_pkg::fetch_state_e;
  import matmul_pkg::ST_IDLE;
  import matmul_pkg::ST_FETCH;
  import matmul_pkg::ST_DRAIN;
  import matmul_pkg::N_SLOTS;

  localparam logic [31:0] C_NBLK = 32'(DIM / 2);

  // Memory-map sanity: both matrices must fit in the address space
  if ((DIM % 2) != 0) begin : g_chk_dim_even
    $error("block_operand_fetch: DIM must be even");
  end
  if ((A_BASE + DIM * DIM) > (2 ** ADDR_W)) begin : g_chk_a_fits
    $error("block_operand_fetch: A matrix exceeds address space");
  end
  if ((B_BASE + DIM * DIM) > (2 ** ADDR_W)) begin : g_chk_b_fits
    $error("block_operand_fetch: B matrix exceeds address space");
  end

  fetch_state_e      state_q;
  logic [2:0]        cnt_q;
  logic [IDX_W-1:0]  idx_i_q;
  logic [IDX_W-1:0]  idx_j_q;
  logic [IDX_W-1:0]  idx_k_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] ops_q [N_SLOTS];

  logic [ADDR_W-1:0] w_gen_addr;
  logic              w_idx_ok;

  assign w_idx_ok = (32'(blk_i) < C_NBLK) && (32'(blk_j) < C_NBLK)
                 && (32'(blk_k) < C_NBLK);

  block_addr_gen #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .DIM    (DIM),
    .A_BASE (A_BASE),
    .B_BASE (B_BASE)
  ) u_addr_gen (
    .blk_i_i (idx_i_q),
    .blk_j_i (idx_j_q),
    .blk_k_i (idx_k_q),
    .slot_i  (cnt_q),
    .addr_o  (w_gen_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_i_q <= '0;
      idx_j_q <= '0;
      idx_k_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int s = 0; s < N_SLOTS; s++) ops_q[s] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (w_idx_ok) begin
              idx_i_q <= blk_i;
              idx_j_q <= blk_j;
              idx_k_q <= blk_k;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_FETCH;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          // Data for the address issued last cycle arrives now
          if (cnt_q != 3'd0) ops_q[cnt_q - 3'd1] <= ram_r_data;
          if (cnt_q == 3'd7) state_q <= ST_DRAIN;
          cnt_q <= cnt_q + 3'd1;
        end
        ST_DRAIN: begin
          ops_q[N_SLOTS-1] <= ram_r_data;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_addr = (state_q == ST_FETCH) ? w_gen_addr : '0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign a_11     = ops_q[0];
  assign a_12     = ops_q[1];
  assign a_21     = ops_q[2];
  assign a_22     = ops_q[3];
  assign b_11     = ops_q[4];
  assign b_12     = ops_q[5];
  assign b_21     = ops_q[6];
  assign b_22     = ops_q[7];

endmodule : block_operand_fetch
`default_nettype wire
